// File: rtl/register_bank_mp.sv
// Multi-port register bank: N combinational write-first read ports, one synchronous write port,
// optional hardwired zero register, and a valid/ready dump engine streaming every register in order.
module register_bank_mp #(
  parameter int NB_DATA      = 32,
  parameter int N_REGISTERS  = 32,
  parameter int NB_REGISTER  = 5,
  parameter int N_READ_PORTS = 2,
  parameter int ZERO_REG     = 1
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_valid,
  input  logic [N_READ_PORTS*NB_REGISTER-1:0] i_read_reg_sel,
  output logic [N_READ_PORTS*NB_DATA-1:0]     o_data_read,
  input  logic [NB_REGISTER-1:0]              i_write_reg_sel,
  input  logic [NB_DATA-1:0]                  i_write_reg_data,
  input  logic                                i_write_reg_enable,
  input  logic                                i_dump_start,
  input  logic                                i_dump_ready,
  output logic                                o_dump_valid,
  output logic [NB_DATA-1:0]                  o_dump_data,
  output logic [NB_REGISTER-1:0]              o_dump_index,
  output logic                                o_dump_busy,
  output logic                                o_dump_done
);

  localparam logic [NB_REGISTER:0]   NREG     = (NB_REGISTER+1)'(N_REGISTERS);
  localparam logic [NB_REGISTER-1:0] LAST_IDX = NB_REGISTER'(N_REGISTERS-1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  logic [NB_DATA-1:0]     regs_q [N_REGISTERS];
  logic                   wr_legal;

  state_t                 state_q, state_d;
  logic                   dump_valid_q, dump_valid_d;
  logic [NB_DATA-1:0]     dump_data_q, dump_data_d;
  logic [NB_REGISTER-1:0] dump_index_q, dump_index_d;
  logic [NB_REGISTER-1:0] load_idx;
  logic [NB_DATA-1:0]     load_word;

  // Out-of-range selects and the hardwired zero register never match, so they read as 0.
  function automatic logic [NB_DATA-1:0] stored_word(input logic [NB_REGISTER-1:0] sel);
    logic [NB_DATA-1:0] w;
    w = '0;
    for (int i = 0; i < N_REGISTERS; i++) begin
      if ((sel == NB_REGISTER'(i)) && !((ZERO_REG != 0) && (i == 0))) w = regs_q[i];
    end
    return w;
  endfunction

  assign wr_legal = i_valid && i_write_reg_enable &&
                    ({1'b0, i_write_reg_sel} < NREG) &&
                    !((ZERO_REG != 0) && (i_write_reg_sel == '0));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_REGISTERS; i++) regs_q[i] <= '0;
    end else if (wr_legal) begin
      for (int i = 0; i < N_REGISTERS; i++) begin
        if (i_write_reg_sel == NB_REGISTER'(i)) regs_q[i] <= i_write_reg_data;
      end
    end
  end

  always_comb begin
    logic [NB_REGISTER-1:0] rd_sel;
    rd_sel      = '0;
    o_data_read = '0;
    for (int k = 0; k < N_READ_PORTS; k++) begin
      rd_sel = i_read_reg_sel[k*NB_REGISTER +: NB_REGISTER];
      if (wr_legal && (rd_sel == i_write_reg_sel))
        o_data_read[k*NB_DATA +: NB_DATA] = i_write_reg_data;
      else
        o_data_read[k*NB_DATA +: NB_DATA] = stored_word(rd_sel);
    end
  end

  // In SEND the next word is fetched while the current one is being accepted.
  assign load_idx  = (state_q == SEND) ? dump_index_q + 1'b1 : dump_index_q;
  assign load_word = stored_word(load_idx);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_index_q <= '0;
    end else begin
      state_q      <= state_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_index_q <= dump_index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_index_d = dump_index_q;
    case (state_q)
      IDLE: begin
        if (i_dump_start) begin
          state_d      = LOAD;
          dump_index_d = '0;
        end
      end
      LOAD: begin
        dump_data_d  = load_word;
        dump_valid_d = 1'b1;
        state_d      = SEND;
      end
      SEND: begin
        if (i_dump_ready) begin
          if (dump_index_q == LAST_IDX) begin
            dump_valid_d = 1'b0;
            state_d      = DONE;
          end else begin
            dump_index_d = load_idx;
            dump_data_d  = load_word;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_dump_valid = dump_valid_q;
    o_dump_data  = dump_data_q;
    o_dump_index = dump_index_q;
    o_dump_busy  = (state_q != IDLE);
    o_dump_done  = (state_q == DONE);
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp: model-based read checks plus a dump scoreboard drained by a monitor.
module tb_register_bank_mp;

  logic        clk, rst_n;
  logic        valid, we, dstart, dready;
  logic [9:0]  rsel;
  logic [63:0] rdata;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic        dvalid, dbusy, ddone;
  logic [31:0] ddata;
  logic [4:0]  dindex;

  logic        b_valid, b_we, b_zero;
  logic [9:0]  b_rsel;
  logic [63:0] b_rdata;
  logic [4:0]  b_wsel;
  logic [31:0] b_wdata;
  logic        b_dvalid, b_dbusy, b_ddone;
  logic [31:0] b_ddata;
  logic [4:0]  b_dindex;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int idx; logic [31:0] dat;} dw_t;
  dw_t         expq[$];
  logic [31:0] mdl [32];

  register_bank_mp dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid),
    .i_read_reg_sel(rsel), .o_data_read(rdata),
    .i_write_reg_sel(wsel), .i_write_reg_data(wdata), .i_write_reg_enable(we),
    .i_dump_start(dstart), .i_dump_ready(dready),
    .o_dump_valid(dvalid), .o_dump_data(ddata), .o_dump_index(dindex),
    .o_dump_busy(dbusy), .o_dump_done(ddone)
  );

  register_bank_mp #(.N_REGISTERS(20)) dut20 (
    .i_clock(clk), .i_reset(rst_n), .i_valid(b_valid),
    .i_read_reg_sel(b_rsel), .o_data_read(b_rdata),
    .i_write_reg_sel(b_wsel), .i_write_reg_data(b_wdata), .i_write_reg_enable(b_we),
    .i_dump_start(b_zero), .i_dump_ready(b_zero),
    .o_dump_valid(b_dvalid), .o_dump_data(b_ddata), .o_dump_index(b_dindex),
    .o_dump_busy(b_dbusy), .o_dump_done(b_ddone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference read rule for the 32-entry, zero-register bank.
  function automatic logic [31:0] exp_rd(input int s, input bit v, input bit e, input int ws,
                                         input logic [31:0] wd);
    if (v && e && ws != 0 && ws < 32 && ws == s) return wd;
    if (s == 0 || s >= 32) return 32'h0;
    return mdl[s];
  endfunction

  task automatic do_write(input int r, input logic [31:0] d);
    valid = 1'b1; we = 1'b1; wsel = 5'(r); wdata = d;
    if (r != 0) mdl[r] = d;
    tick();
    we = 1'b0;
  endtask

  task automatic push_all();
    for (int i = 0; i < 32; i++) expq.push_back('{i, (i == 0) ? 32'h0 : mdl[i]});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!ddone && n < 400) begin
      tick();
      n++;
    end
    check("dump_done_seen", {31'h0, ddone}, 32'h1);
  endtask

  // Dump monitor: pops the scoreboard on every handshake and enforces hold-while-stalled.
  logic        stall = 1'b0;
  logic [31:0] held_d;
  logic [4:0]  held_i;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("dump_valid_held", {31'h0, dvalid}, 32'h1);
        check("dump_stall_data", ddata, held_d);
        check("dump_stall_index", {27'h0, dindex}, {27'h0, held_i});
      end
      if (dvalid && dready) begin
        if (expq.size() == 0) begin
          check("dump_unexpected_word", {27'h0, dindex}, 32'hFFFF_FFFF);
        end else begin
          dw_t e;
          e = expq.pop_front();
          check("dump_index", {27'h0, dindex}, 32'(e.idx));
          check("dump_data", ddata, e.dat);
        end
        stall = 1'b0;
      end else if (dvalid) begin
        stall  = 1'b1;
        held_d = ddata;
        held_i = dindex;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] v;
    bit written;
    valid = 0; we = 0; dstart = 0; dready = 0; rsel = '0; wsel = '0; wdata = '0;
    b_valid = 0; b_we = 0; b_zero = 0; b_rsel = '0; b_wsel = '0; b_wdata = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rsel = {5'd17, 5'd9};
    #1;
    check("rst_dump_valid", {31'h0, dvalid}, 32'h0);
    check("rst_dump_busy", {31'h0, dbusy}, 32'h0);
    check("rst_dump_done", {31'h0, ddone}, 32'h0);
    check("rst_dump_data", ddata, 32'h0);
    check("rst_dump_index", {27'h0, dindex}, 32'h0);
    check("rst_read_p0", rdata[31:0], 32'h0);
    check("rst_read_p1", rdata[63:32], 32'h0);
    rst_n = 1'b1;
    tick();

    // Fill passes.
    for (int p = 0; p < 10; p++) begin
      for (int r = 0; r < 32; r++) do_write(r, $urandom);
      for (int r = 0; r < 32; r++) begin
        rsel = {5'(31 - r), 5'(r)};
        #1;
        check("fill_p0", rdata[31:0], (r == 0) ? 32'h0 : mdl[r]);
        check("fill_p1", rdata[63:32], (r == 31) ? 32'h0 : mdl[31 - r]);
      end
    end

    // Bypass to a real register and to the zero register.
    valid = 1; we = 1; wsel = 5'd7; wdata = 32'hDEADBEEF; rsel = {5'd7, 5'd7};
    #1;
    check("bypass_p0", rdata[31:0], 32'hDEADBEEF);
    check("bypass_p1", rdata[63:32], 32'hDEADBEEF);
    mdl[7] = 32'hDEADBEEF;
    tick(); we = 0; #1;
    check("bypass_after_p0", rdata[31:0], 32'hDEADBEEF);
    check("bypass_after_p1", rdata[63:32], 32'hDEADBEEF);
    we = 1; wsel = 5'd0; wdata = 32'hDEADBEEF; rsel = {5'd0, 5'd0};
    #1;
    check("bypass_zero_p0", rdata[31:0], 32'h0);
    check("bypass_zero_p1", rdata[63:32], 32'h0);
    tick(); we = 0; #1;
    check("zero_after", rdata[31:0], 32'h0);

    // i_valid gating.
    do_write(3, 32'h0BADF00D);
    valid = 0; we = 1; wsel = 5'd3; wdata = 32'h12345678; rsel = {5'd3, 5'd3};
    #1;
    check("gate_no_bypass", rdata[31:0], 32'h0BADF00D);
    tick(); we = 0; #1;
    check("gate_no_write", rdata[63:32], 32'h0BADF00D);

    // 20-register instance: out-of-range writes are dropped.
    b_valid = 1; b_we = 1; b_wsel = 5'd25; b_wdata = 32'hCAFE0025; b_rsel = {5'd25, 5'd25};
    #1;
    check("n20_oob_bypass", b_rdata[31:0], 32'h0);
    tick(); b_we = 0; #1;
    check("n20_oob_read", b_rdata[63:32], 32'h0);
    b_we = 1; b_wsel = 5'd19; b_wdata = 32'h19191919;
    tick(); b_we = 0; b_rsel = {5'd20, 5'd19}; #1;
    check("n20_last_reg", b_rdata[31:0], 32'h19191919);
    check("n20_sel20", b_rdata[63:32], 32'h0);

    // Random read/write traffic against the model.
    for (int it = 0; it < 300; it++) begin
      valid = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      wsel  = 5'($urandom_range(0, 31));
      wdata = $urandom;
      rsel  = {5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? wsel : 5'($urandom_range(0, 31))};
      #1;
      check("rand_p0", rdata[31:0], exp_rd(int'(rsel[4:0]), valid, we, int'(wsel), wdata));
      check("rand_p1", rdata[63:32], exp_rd(int'(rsel[9:5]), valid, we, int'(wsel), wdata));
      if (valid && we && wsel != 0) mdl[wsel] = wdata;
      tick();
    end
    we = 0;

    // Full dump with ready held high.
    for (int r = 1; r < 32; r++) do_write(r, 32'(r) * 32'h01010101);
    dready = 1;
    push_all();
    dstart = 1;
    tick();
    dstart = 0;
    n = 1;
    while (!ddone && n < 400) begin
      tick();
      n++;
    end
    check("full_dump_cycles", 32'(n), 32'd34);
    tick();
    check("done_one_cycle", {31'h0, ddone}, 32'h0);
    check("idle_after_done", {31'h0, dbusy}, 32'h0);
    check("full_dump_drained", 32'(expq.size()), 32'h0);

    // Backpressure, ignored restart, write during dump.
    push_all();
    dstart = 1;
    tick();
    dstart = 0;
    written = 0;
    for (int c = 0; c < 600 && !ddone; c++) begin
      dready = 1'($urandom_range(0, 1));
      dstart = (c == 20);
      if (!written && dvalid && dindex == 5'd5) begin
        valid = 1; we = 1; wsel = 5'd31; wdata = 32'hCAFEF00D;
        mdl[31] = 32'hCAFEF00D;
        foreach (expq[j]) if (expq[j].idx == 31) expq[j].dat = 32'hCAFEF00D;
        written = 1;
      end else begin
        we = 0;
      end
      tick();
    end
    dstart = 0; we = 0;
    check("bp_done_seen", {31'h0, ddone}, 32'h1);
    check("bp_write_issued", {31'h0, written}, 32'h1);
    dready = 1;
    repeat (4) tick();
    check("bp_no_restart", {31'h0, dbusy}, 32'h0);
    check("bp_drained", 32'(expq.size()), 32'h0);

    // Reset in the middle of a dump.
    push_all();
    dstart = 1;
    tick();
    dstart = 0;
    n = 0;
    while (!(dvalid && dindex == 5'd10) && n < 100) begin
      tick();
      n++;
    end
    check("reach_index10", {27'h0, dindex}, 32'd10);
    rst_n = 0;
    #1;
    check("mid_rst_valid", {31'h0, dvalid}, 32'h0);
    check("mid_rst_busy", {31'h0, dbusy}, 32'h0);
    check("mid_rst_done", {31'h0, ddone}, 32'h0);
    rsel = {5'd31, 5'd5};
    #1;
    check("mid_rst_reg5", rdata[31:0], 32'h0);
    check("mid_rst_reg31", rdata[63:32], 32'h0);
    expq.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    tick();
    rst_n = 1;
    tick();
    push_all();
    dstart = 1;
    tick();
    dstart = 0;
    wait_done(n);
    tick();
    check("zero_dump_drained", 32'(expq.size()), 32'h0);
    v = {31'h0, dbusy};
    check("final_idle", v, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_mp.md
Name: register_bank_mp

Overview:
- Parametrised successor to the single-pair register bank in the MIPS datapath.
- Provides N_READ_PORTS combinational read ports with write-through bypass, one synchronous write port, and an optionally hardwired zero register.
- Adds a dump engine: an FSM that streams every register, in index order, to the debug unit over a valid/ready handshake.
- Sits between decode (reads), write-back (writes) and the debug unit (dump).

Parameters:
NB_DATA, 32, register width in bits
N_REGISTERS, 32, number of registers (2..2^NB_REGISTER)
NB_REGISTER, 5, select width
N_READ_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
i_clock  in  1  single clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  pipeline advance enable; gates writes only
i_read_reg_sel  in  N_READ_PORTS*NB_REGISTER  read selects; port k uses slice k
o_data_read  out  N_READ_PORTS*NB_DATA  read data; port k uses slice k
i_write_reg_sel  in  NB_REGISTER  write select
i_write_reg_data  in  NB_DATA  write data
i_write_reg_enable  in  1  write request
i_dump_start  in  1  start-dump request
i_dump_ready  in  1  debug unit accepts the current dump word
o_dump_valid  out  1  dump word present
o_dump_data  out  NB_DATA  dump word
o_dump_index  out  NB_REGISTER  index of the dump word
o_dump_busy  out  1  dump in progress
o_dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (i_reset=0, asynchronous): all registers 0; FSM to IDLE; o_dump_valid, o_dump_data, o_dump_index, o_dump_busy, o_dump_done all 0. A reset during a dump aborts it; no done pulse is produced.
- Write: a register is written on the rising edge when i_valid & i_write_reg_enable & write target legal.
  - Legal: i_write_reg_sel < N_REGISTERS, and not (ZERO_REG=1 and i_write_reg_sel=0).
  - Illegal targets are silently ignored.
  - i_valid=0 blocks all writes.
- Read: combinational on every port.
  - Select >= N_REGISTERS returns 0.
  - Select 0 with ZERO_REG=1 returns 0.
  - Bypass: if a legal write is pending this cycle to the same select, the port returns i_write_reg_data (write-first). An illegal write never bypasses.
  - Read ports are fully independent; identical selects on several ports are allowed.
- Dump FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: o_dump_busy=0. On i_dump_start=1, go to LOAD with index=0.
  - LOAD (1 cycle): register o_dump_data <= stored value of reg[index] from the array (no bypass; reg0 is 0 when ZERO_REG=1), o_dump_index <= index, o_dump_valid <= 1. Go to SEND.
  - SEND: hold o_dump_valid, data and index stable until i_dump_ready=1.
    - On handshake with index = N_REGISTERS-1: drop valid, go to DONE.
    - Otherwise: increment index and load the next word in the same cycle (back-to-back; one word per cycle when ready is held high).
  - DONE (1 cycle): o_dump_done=1, o_dump_busy=1. Then return to IDLE.
  - o_dump_busy=1 in LOAD, SEND and DONE.
- Latency: start sampled at edge t; o_dump_valid=1 with index 0 after edge t+1. A full dump with ready held high takes N_REGISTERS+2 cycles from start to done.
- i_dump_start while busy: ignored (no restart, no queuing).
- Writes during a dump:
  - Always permitted.
  - A word already loaded into o_dump_data is not changed.
  - A register not yet reached is dumped with its new value.
- The dump engine ignores i_valid, so the debug unit can dump a halted pipeline.
- o_dump_valid never drops without a handshake, except on reset.

Test Plan:
- Reset then fill: write random values to regs 0..31 with i_valid=1, then read all on both ports -> reg0 reads 0, regs 1..31 match the written values; repeat 10 random passes.
- Bypass: write 0xDEADBEEF to reg 7 while port0 sel=7 and port1 sel=7 in the same cycle -> both ports show 0xDEADBEEF combinationally; the next cycle with the write deasserted still reads 0xDEADBEEF. Same case with sel=0 -> reads 0.
- Valid gating: i_valid=0 with write reg 3 = 0x12345678 -> reg 3 keeps its old value and no bypass; N_REGISTERS=20 with write to sel 25 -> ignored, reads 0.
- Full dump, ready=1: regs hold index*0x01010101, pulse start -> 32 consecutive valid cycles with index 0..31 and matching data; done pulse exactly 1 cycle after index 31; total 34 cycles.
- Backpressure and concurrency: ready toggling pseudo-randomly, second start mid-dump, write reg 31 = 0xCAFEF00D at index 5 -> no word lost or duplicated; data is stable while stalled; the second start is ignored; index 31 dumps 0xCAFEF00D.
- Reset mid-dump: assert i_reset=0 at index 10 -> valid, busy and done drop to 0 immediately with all registers cleared; a fresh start afterwards dumps all zeros.
